// File: rtl/cpu_defs_pkg.sv
// Shared opcode constants, sequencer state encodings and IR field layout
// used by the control sequencer and its register decoders.
package cpu_defs_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_T0   = 3'd0;
  localparam state_t ST_T1   = 3'd1;
  localparam state_t ST_T2   = 3'd2;
  localparam state_t ST_T3   = 3'd3;
  localparam state_t ST_T4   = 3'd4;
  localparam state_t ST_T5   = 3'd5;
  localparam state_t ST_T6   = 3'd6;
  localparam state_t ST_HALT = 3'd7;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Upper 17 bits of the IR; the low 15 bits are immediate/unused here.
  typedef struct packed {
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } ir_fields_t;

  function automatic logic op_is_muldiv(logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // The two-operand ALU ops occupy a contiguous opcode range plus MUL/DIV.
  function automatic logic op_is_binary(logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_ROL)) || op_is_muldiv(op);
  endfunction

  function automatic logic op_is_unary(logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// 4-to-16 one-hot register select decoder with enable; all-zero when disabled.
module reg_decoder_4to16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
      assign onehot[gi] = en && (sel == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer: fetch (T0..T2) then an opcode-dependent
// execute/writeback tail. Control outputs are decoded combinationally from state and IR.
module control_sequencer
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  output logic        PC_out,
  output logic        MDR_out,
  output logic        Zlo_out,
  output logic        Zhi_out,
  output logic [15:0] R_wrt,
  output logic        MAR_rd,
  output logic        PC_rd,
  output logic        MDR_rd,
  output logic        IR_rd,
  output logic        Y_rd,
  output logic        Zlo_rd,
  output logic        HI_rd,
  output logic        LO_rd,
  output logic [15:0] R_rd,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  op_sel,
  output logic        halted
);

  state_t     state_reg;
  state_t     state_next;
  ir_fields_t fields;
  logic       is_binary;
  logic       is_unary;
  logic       is_muldiv;
  logic       is_halt;
  logic       wrt_en;
  logic [3:0] wrt_sel;
  logic       rd_en;
  logic       unused_ir_bits;

  assign fields         = ir[31:15];
  assign unused_ir_bits = ^ir[14:0];
  assign is_binary      = op_is_binary(fields.op);
  assign is_unary       = op_is_unary(fields.op);
  assign is_muldiv      = op_is_muldiv(fields.op);
  assign is_halt        = (fields.op == OP_HALT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= ST_T0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_T0: if (run) state_next = ST_T1;
      ST_T1: if (mem_rdy) state_next = ST_T2;
      ST_T2: state_next = ST_T3;
      ST_T3: begin
        if (is_binary)     state_next = ST_T4;
        else if (is_unary) state_next = ST_T5;
        else if (is_halt)  state_next = ST_HALT;
        else               state_next = ST_T0;
      end
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = is_muldiv ? ST_T6 : ST_T0;
      ST_T6:   state_next = ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_T0;
    endcase
  end

  // Register bus drive: Rb in T3 (binary and unary), Rc in T4.
  // Outputs are masked while clr is high so the async reset is visible at once.
  assign wrt_en  = !clr && (((state_reg == ST_T3) && (is_binary || is_unary)) ||
                            (state_reg == ST_T4));
  assign wrt_sel = (state_reg == ST_T4) ? fields.rc : fields.rb;
  assign rd_en   = !clr && (state_reg == ST_T5) && !is_muldiv;

  reg_decoder_4to16 u_wrt_dec (
    .sel    (wrt_sel),
    .en     (wrt_en),
    .onehot (R_wrt)
  );

  reg_decoder_4to16 u_rd_dec (
    .sel    (fields.ra),
    .en     (rd_en),
    .onehot (R_rd)
  );

  always_comb begin
    PC_out  = 1'b0;
    MDR_out = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    MAR_rd  = 1'b0;
    PC_rd   = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    HI_rd   = 1'b0;
    LO_rd   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    op_sel  = 5'b0;
    halted  = 1'b0;
    if (!clr) begin
      case (state_reg)
        ST_T0: begin
          if (run) begin
            PC_out = 1'b1;
            MAR_rd = 1'b1;
            IncPC  = 1'b1;
            Zlo_rd = 1'b1;
          end
        end
        // Held while mem_rdy is low; re-latching PC+1 each cycle is benign.
        ST_T1: begin
          Zlo_out = 1'b1;
          PC_rd   = 1'b1;
          Read    = 1'b1;
          MDR_rd  = 1'b1;
        end
        ST_T2: begin
          MDR_out = 1'b1;
          IR_rd   = 1'b1;
        end
        ST_T3: begin
          if (is_binary) begin
            Y_rd = 1'b1;
          end else if (is_unary) begin
            op_sel = fields.op;
            Zlo_rd = 1'b1;
          end
        end
        ST_T4: begin
          op_sel = fields.op;
          Zlo_rd = 1'b1;
        end
        ST_T5: begin
          Zlo_out = 1'b1;
          LO_rd   = is_muldiv;
        end
        ST_T6: begin
          Zhi_out = 1'b1;
          HI_rd   = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction expands into per-cycle
// expected control words that are queued with their stimulus and checked one per cycle.
module tb_control_sequencer;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic        clk;
  logic        clr;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic        PC_out, MDR_out, Zlo_out, Zhi_out;
  logic [15:0] R_wrt, R_rd;
  logic        MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd;
  logic        IncPC, Read, halted;
  logic [4:0]  op_sel;

  typedef struct packed {
    logic        pc_out;
    logic        mdr_out;
    logic        zlo_out;
    logic        zhi_out;
    logic [15:0] r_wrt;
    logic        mar_rd;
    logic        pc_rd;
    logic        mdr_rd;
    logic        ir_rd;
    logic        y_rd;
    logic        zlo_rd;
    logic        hi_rd;
    logic        lo_rd;
    logic [15:0] r_rd;
    logic        inc_pc;
    logic        read;
    logic [4:0]  op_sel;
    logic        halted;
  } outs_t;

  typedef struct {
    int          st;
    logic        run;
    logic        rdy;
    logic [31:0] ir;
    outs_t       exp;
  } step_t;

  outs_t obs;
  step_t sb_q[$];
  outs_t hist[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  assign obs = {PC_out, MDR_out, Zlo_out, Zhi_out, R_wrt, MAR_rd, PC_rd, MDR_rd, IR_rd,
                Y_rd, Zlo_rd, HI_rd, LO_rd, R_rd, IncPC, Read, op_sel, halted};

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out),
    .R_wrt(R_wrt), .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
    .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .HI_rd(HI_rd), .LO_rd(LO_rd), .R_rd(R_rd),
    .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic is_bin(logic [4:0] op);
    return (op inside {[5'b00011:5'b01011]}) || op == 5'b01111 || op == 5'b10000;
  endfunction

  function automatic logic is_un(logic [4:0] op);
    return op == 5'b10001 || op == 5'b10010;
  endfunction

  function automatic logic is_md(logic [4:0] op);
    return op == 5'b01111 || op == 5'b10000;
  endfunction

  // Control word the specification lists for each T-state.
  function automatic outs_t exp_of(int st, logic [31:0] iv, logic run_in);
    outs_t      e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    e  = '0;
    op = iv[31:27];
    ra = iv[26:23];
    rb = iv[22:19];
    rc = iv[18:15];
    case (st)
      0: if (run_in) begin e.pc_out = 1; e.mar_rd = 1; e.inc_pc = 1; e.zlo_rd = 1; end
      1: begin e.zlo_out = 1; e.pc_rd = 1; e.read = 1; e.mdr_rd = 1; end
      2: begin e.mdr_out = 1; e.ir_rd = 1; end
      3: begin
        if (is_bin(op)) begin
          e.r_wrt = 16'h1 << rb; e.y_rd = 1;
        end else if (is_un(op)) begin
          e.r_wrt = 16'h1 << rb; e.op_sel = op; e.zlo_rd = 1;
        end
      end
      4: begin e.r_wrt = 16'h1 << rc; e.op_sel = op; e.zlo_rd = 1; end
      5: begin
        e.zlo_out = 1;
        if (is_md(op)) e.lo_rd = 1;
        else           e.r_rd = 16'h1 << ra;
      end
      6: begin e.zhi_out = 1; e.hi_rd = 1; end
      7: e.halted = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic add_step(input int st, input logic run_in, input logic rdy, input logic [31:0] iv);
    step_t s;
    s.st  = st;
    s.run = run_in;
    s.rdy = rdy;
    s.ir  = iv;
    s.exp = exp_of(st, iv, run_in);
    sb_q.push_back(s);
  endtask

  // Expand one instruction into its state walk; max_steps truncates it.
  task automatic push_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input int stall, input int max_steps);
    logic [31:0] iv;
    int          seq[$];
    logic        rdy_q[$];
    iv = {op, ra, rb, rc, 15'h0};
    seq.push_back(0); rdy_q.push_back(1'b1);
    for (int i = 0; i <= stall; i++) begin
      seq.push_back(1);
      rdy_q.push_back(i == stall);
    end
    seq.push_back(2); rdy_q.push_back(1'b1);
    seq.push_back(3); rdy_q.push_back(1'b1);
    if (is_bin(op)) begin
      seq.push_back(4); rdy_q.push_back(1'b1);
      seq.push_back(5); rdy_q.push_back(1'b1);
      if (is_md(op)) begin seq.push_back(6); rdy_q.push_back(1'b1); end
    end else if (is_un(op)) begin
      seq.push_back(5); rdy_q.push_back(1'b1);
    end else if (op == OP_HALT) begin
      for (int i = 0; i < 20; i++) begin seq.push_back(7); rdy_q.push_back(1'b1); end
    end
    for (int i = 0; i < seq.size() && i < max_steps; i++) add_step(seq[i], 1'b1, rdy_q[i], iv);
  endtask

  task automatic push_idle(input logic [31:0] iv);
    add_step(0, 1'b0, 1'b1, iv);
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step();
    step_t s;
    int    n;
    s = sb_q.pop_front();
    ir      = s.ir;
    run     = s.run;
    mem_rdy = s.rdy;
    @(negedge clk);
    check($sformatf("T%0d_ir%h", s.st, s.ir), 64'(obs), 64'(s.exp));
    n = $countones({PC_out, MDR_out, Zlo_out, Zhi_out, R_wrt});
    check("bus_1hot", 64'(n <= 1), 64'd1);
    hist.push_back(obs);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (sb_q.size() > 0) step();
  endtask

  initial begin
    int cnt;
    logic [31:0] iv;
    clr = 1'b1; run = 1'b1; mem_rdy = 1'b1; ir = 32'h0;
    #2;
    check("reset_async", 64'(obs), 64'd0);
    @(posedge clk); @(negedge clk);
    check("reset_outs", 64'(obs), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;

    // ROL R4,R3,R7 (ir 5A1B8000)
    hist.delete();
    push_instr(OP_ROL, 4'd4, 4'd3, 4'd7, 0, 99);
    push_idle(32'h5A1B8000);
    drain();
    check("rol_t3_rwrt", 64'(hist[3].r_wrt), 64'h0008);
    check("rol_t3_yrd", 64'(hist[3].y_rd), 64'd1);
    check("rol_t4_rwrt", 64'(hist[4].r_wrt), 64'h0080);
    check("rol_t4_opsel", 64'(hist[4].op_sel), 64'(5'b01011));
    check("rol_t5_rrd", 64'(hist[5].r_rd), 64'h0010);
    check("rol_back_t0", 64'(hist[6]), 64'd0);

    // ADD with three fetch stall cycles
    hist.delete();
    push_instr(OP_ADD, 4'd9, 4'd1, 4'd15, 3, 99);
    drain();
    cnt = 0;
    foreach (hist[i]) if (hist[i].read) cnt++;
    check("stall_read_cycles", 64'(cnt), 64'd4);
    check("stall_t2_after_rdy", 64'(hist[5].ir_rd), 64'd1);

    // MUL R2,R5,R6 then idle
    hist.delete();
    push_instr(OP_MUL, 4'd2, 4'd5, 4'd6, 0, 99);
    push_idle({OP_MUL, 4'd2, 4'd5, 4'd6, 15'h0});
    drain();
    check("mul_t5_lord", 64'({hist[5].lo_rd, hist[5].zlo_out}), 64'b11);
    check("mul_t6_hird", 64'({hist[6].hi_rd, hist[6].zhi_out}), 64'b11);
    check("mul_7cyc_t0", 64'(hist[7]), 64'd0);

    // NOT R1,R2 then idle
    hist.delete();
    push_instr(OP_NOT, 4'd1, 4'd2, 4'd0, 0, 99);
    push_idle({OP_NOT, 4'd1, 4'd2, 4'd0, 15'h0});
    drain();
    check("not_t3_rwrt", 64'(hist[3].r_wrt), 64'h0004);
    check("not_t5_rrd", 64'(hist[4].r_rd), 64'h0002);
    cnt = 0;
    foreach (hist[i]) if (hist[i].y_rd) cnt++;
    check("not_no_yrd", 64'(cnt), 64'd0);
    check("not_5cyc_t0", 64'(hist[5]), 64'd0);

    // NOP takes four cycles, then another instruction starts
    hist.delete();
    push_instr(OP_NOP, 4'd3, 4'd3, 4'd3, 0, 99);
    push_instr(OP_ADD, 4'd0, 4'd14, 4'd2, 1, 99);
    drain();
    check("nop_4cyc_next_t0", 64'(hist[4].pc_out), 64'd1);

    // HALT: 20 halted cycles, then clr recovers
    push_instr(OP_HALT, 4'd0, 4'd0, 4'd0, 0, 99);
    drain();
    clr = 1'b1;
    #1;
    check("halt_clr_outs", 64'(obs), 64'd0);
    run = 1'b0;
    #1;
    clr = 1'b0;
    @(posedge clk); #1;
    push_idle(32'h0);
    push_instr(OP_ADD, 4'd5, 4'd6, 4'd7, 0, 99);
    drain();

    // Async clr in the middle of T4
    iv = {OP_ADD, 4'd8, 4'd10, 4'd12, 15'h0};
    push_instr(OP_ADD, 4'd8, 4'd10, 4'd12, 0, 4);
    drain();
    @(negedge clk);
    check("t4_before_clr", 64'(obs), 64'(exp_of(4, iv, 1'b1)));
    #1;
    clr = 1'b1;
    #1;
    check("clr_mid_outs", 64'(obs), 64'd0);
    check("clr_mid_1hot", 64'($countones({PC_out, MDR_out, Zlo_out, Zhi_out, R_wrt}) <= 1), 64'd1);
    run = 1'b0;
    #1;
    clr = 1'b0;
    @(posedge clk); #1;
    push_idle(iv);
    push_instr(OP_MUL, 4'd11, 4'd13, 4'd0, 0, 99);
    push_idle(iv);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
